// File: rtl/score_max_issuer_if.sv
// ============================================================================
// score_max_issuer_if : score/V stream in, expmul beat plus rescale sideband out
// Revision: 1.0
// ============================================================================
`default_nettype none

interface score_max_issuer_if #(
   parameter int INT_W = 16,
   parameter int V_W   = 32
);
   logic                    vld_in;
   logic                    rdy_out;
   logic signed [INT_W-1:0] score_in;
   logic        [V_W-1:0]   v_in;
   logic                    vld_out;
   logic                    rdy_in;
   logic signed [INT_W-1:0] a_out;
   logic signed [INT_W-1:0] b_out;
   logic        [V_W-1:0]   v_out;
   logic signed [INT_W-1:0] m_prev_out;
   logic                    max_upd_out;
   logic                    row_first_out;
   logic                    row_last_out;

   modport slave (
      input  vld_in, score_in, v_in, rdy_in,
      output rdy_out, vld_out, a_out, b_out, v_out, m_prev_out,
             max_upd_out, row_first_out, row_last_out
   );

   modport master (
      output vld_in, score_in, v_in, rdy_in,
      input  rdy_out, vld_out, a_out, b_out, v_out, m_prev_out,
             max_upd_out, row_first_out, row_last_out
   );
endinterface

`default_nettype wire

// File: rtl/score_max_issuer.sv
// ============================================================================
// score_max_issuer : online-softmax running max tracker feeding expmul
// Revision: 1.0
// ============================================================================
`default_nettype none

module score_max_issuer #(
   parameter int ROW_LEN = 64,
   parameter int INT_W   = 16,
   parameter int V_W     = 32,
   parameter int CNT_W   = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1
) (
   input  wire logic          clk,
   input  wire logic          rst,
   score_max_issuer_if.slave  bus
);
   typedef enum logic [0:0] {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

   state_t                  state;
   state_t                  state_nxt;
   logic [CNT_W-1:0]        col;
   logic signed [INT_W-1:0] max_q;

   logic                    accept;
   logic                    is_last;
   logic                    gt;
   logic signed [INT_W-1:0] m_new;
   logic signed [INT_W-1:0] m_prev;
   logic                    upd;

   assign bus.rdy_out = !bus.vld_out || bus.rdy_in;
   assign accept      = bus.vld_in && bus.rdy_out;
   assign is_last     = (col == CNT_W'(ROW_LEN - 1));

   always_comb begin
      state_nxt = state;
      gt        = bus.score_in > max_q;
      m_new     = bus.score_in;
      m_prev    = bus.score_in;
      upd       = 1'b0;
      // In IDLE the max register is stale, so the score seeds the row
      if (state == ACTIVE) begin
         m_prev = max_q;
         m_new  = gt ? bus.score_in : max_q;
         upd    = gt;
      end
      if (accept) begin
         state_nxt = is_last ? IDLE : ACTIVE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         col   <= '0;
         max_q <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            max_q <= m_new;
            col   <= is_last ? '0 : col + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.vld_out       <= 1'b0;
         bus.a_out         <= '0;
         bus.b_out         <= '0;
         bus.v_out         <= '0;
         bus.m_prev_out    <= '0;
         bus.max_upd_out   <= 1'b0;
         bus.row_first_out <= 1'b0;
         bus.row_last_out  <= 1'b0;
      end else if (accept) begin
         bus.vld_out       <= 1'b1;
         bus.a_out         <= bus.score_in;
         bus.b_out         <= m_new;
         bus.v_out         <= bus.v_in;
         bus.m_prev_out    <= m_prev;
         bus.max_upd_out   <= upd;
         bus.row_first_out <= (state == IDLE);
         bus.row_last_out  <= is_last;
      end else if (bus.rdy_in) begin
         bus.vld_out <= 1'b0;
      end
   end
endmodule

`default_nettype wire

// File: doc/score_max_issuer.md
# score_max_issuer

Transmitter stage that feeds the `expmul` input port. For each key position it takes one attention score and its V vector. It tracks the running row maximum (online-softmax max) and issues `(a = score, b = running max, v)` beats toward `expmul`. It also sends sideband data so the downstream accumulator can rescale by exp(m_prev − m_new) when the max rises. It sits between the QK dot-product stage and `expmul`, one instance per query lane.

## Interface
- ROW_LEN, 64: key positions per query row; must be ≥ 1.
- CNT_W, $clog2(ROW_LEN) (minimum 1): width of the column counter.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- vld_in  in  1  upstream score/V beat valid.
- rdy_out  out  1  this block can accept an upstream beat.
- score_in  in  INT_T  signed QK score.
- v_in  in  V_VECTOR_T  V vector paired with score_in.
- vld_out  out  1  beat valid toward `expmul`.
- rdy_in  in  1  `expmul` ready.
- a_out  out  INT_T  the score (drives `expmul` a_in).
- b_out  out  INT_T  running max including this score (drives `expmul` b_in).
- v_out  out  V_VECTOR_T  V vector (drives `expmul` v_in).
- m_prev_out  out  INT_T  running max before this score; equals score on the first beat of a row.
- max_upd_out  out  1  this beat raised the running max (b_out ≠ m_prev_out).
- row_first_out  out  1  beat is column 0 of its row.
- row_last_out  out  1  beat is column ROW_LEN−1 of its row.

## Operation
- Input handshake: a beat is accepted when `vld_in && rdy_out`.
- Output handshake: a beat is consumed when `vld_out && rdy_in`.
- rdy_out = !vld_out || rdy_in. An empty output register always accepts, and a full one accepts only when it drains in the same cycle.
- State machine:
  - IDLE: no row open, max invalid.
  - ACTIVE: row open, max valid.
  - IDLE → ACTIVE on an accepted beat when ROW_LEN > 1.
  - ACTIVE → IDLE on an accepted beat with col == ROW_LEN−1.
  - ROW_LEN == 1: stays in IDLE; every beat is both first and last.
- Max rule for an accepted beat:
  - IDLE: m_new = score, m_prev = score, max_upd = 0, row_first = 1.
  - ACTIVE: m_new = (score > max) ? score : max, using a signed compare. m_prev = max. max_upd = (score > max), so a tie gives 0. row_first = 0.
  - The max register loads m_new on every accepted beat, including the last one. Its value is don't-care in IDLE.
- Column counter `col` (CNT_W bits):
  - Increments on each accepted beat.
  - When col == ROW_LEN−1 the beat is marked row_last and col returns to 0; it never runs past ROW_LEN−1.
- Output register: one stage holding a, b, v, m_prev, max_upd, row_first, row_last.
  - Loads on an accepted input beat.
  - Otherwise, vld_out clears when rdy_in = 1.
  - Holds all fields stable while `vld_out && !rdy_in`.
- No arithmetic beyond compare/select. b_out ≥ a_out always holds, so a−b ≤ 0 inside `expmul`.

## Timing
- Latency: an input accepted at edge N appears on the outputs with vld_out = 1 after edge N. That is one cycle of latency.
- Throughput: one beat per cycle while rdy_in stays high.
- Backpressure: with rdy_in = 0 and vld_out = 1, rdy_out = 0, and max, col and state are frozen.
- Simultaneous drain and fill: rdy_in = 1, vld_out = 1 and vld_in = 1 in the same cycle loads the new beat with no bubble.
- Reset values (asynchronous, applied immediately):
  - state = IDLE, col = 0, max = 0.
  - vld_out = 0, and all output data/sideband fields = 0.
  - rdy_out = 1 once reset deasserts.
- Reset mid-row discards the open row and any held output beat. The first beat after reset is treated as row_first.
- vld_in must not depend on rdy_out. score_in and v_in are sampled only on acceptance.

## Test plan
- ROW_LEN = 4, rdy_in held 1, scores 3, 7, 7, −2 → b_out = 3, 7, 7, 7; m_prev_out = 3, 3, 7, 7; max_upd_out = 0, 1, 0, 0; row_first on beat 0 and row_last on beat 3; every beat appears 1 cycle after acceptance.
- Signed compare: scores −5, −8, −1 → b_out = −5, −5, −1; max_upd_out = 0, 0, 1.
- Backpressure: rdy_in = 0 for 3 cycles while outputting beat 1 → rdy_out = 0, and a_out, b_out and v_out stay unchanged. When rdy_in returns to 1, beat 2 follows with no loss or duplication.
- Row wrap: 8 beats with ROW_LEN = 4, second-row scores 0, 1, 2, 3 → beat 4 has row_first = 1 and m_prev_out = b_out = 0, with no carry-over from the first row's max.
- Reset mid-row: assert rst after 2 of 4 beats with vld_out high → vld_out drops immediately; the next beat after release has row_first = 1 and col restarts at 0.
- ROW_LEN = 1: scores 9, 2 → both beats have row_first = row_last = 1, b_out = a_out, and max_upd_out = 0.
